// File: rtl/pc_nzp_unit_if.sv
// pc_nzp_unit_if: lane-side bundle between decode/ALU and the PC/NZP unit.
// master drives instruction state; slave returns next PC and flag status.
interface pc_nzp_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;

  logic                enable;
  logic [2:0]          core_state;
  logic [PC_WIDTH-1:0] current_pc;
  logic [2:0]          decoded_nzp;
  logic [PC_WIDTH-1:0] decoded_immediate;
  logic                decoded_pc_mux;
  logic                decoded_call;
  logic                decoded_ret;
  logic                decoded_nzp_write_enable;
  logic [7:0]          alu_out;
  logic [PC_WIDTH-1:0] next_pc;
  logic [2:0]          nzp;
  logic [DW-1:0]       stack_depth;
  logic                stack_overflow;
  logic                stack_underflow;

  modport master (
    output enable, core_state, current_pc,
    output decoded_nzp, decoded_immediate,
    output decoded_pc_mux, decoded_call,
    output decoded_ret,
    output decoded_nzp_write_enable, alu_out,
    input  next_pc, nzp, stack_depth,
    input  stack_overflow, stack_underflow
  );

  modport slave (
    input  enable, core_state, current_pc,
    input  decoded_nzp, decoded_immediate,
    input  decoded_pc_mux, decoded_call,
    input  decoded_ret,
    input  decoded_nzp_write_enable, alu_out,
    output next_pc, nzp, stack_depth,
    output stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_nzp_unit.sv
// pc_nzp_unit: per-thread NZP flag latch, branch resolve,
// next-PC register and return-address stack.
module pc_nzp_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  pc_nzp_unit_if.slave bus
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;
  localparam int AW = $clog2(STACK_DEPTH);

  localparam logic [2:0] ST_EXEC = 3'b101;
  localparam logic [2:0] ST_UPD  = 3'b110;

  logic [PC_WIDTH-1:0] r_next_pc;
  logic [2:0]          r_nzp;
  logic [DW-1:0]       r_depth;
  logic                r_ovf;
  logic                r_unf;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [PC_WIDTH-1:0] w_seq;
  logic                w_exec;
  logic                w_upd;
  logic                w_full;
  logic                w_empty;
  logic                w_taken;
  logic [DW-1:0]       w_depth_m1;
  logic [AW-1:0]       w_top_idx;
  logic [AW-1:0]       w_push_idx;
  logic [PC_WIDTH-1:0] w_top;

  logic [PC_WIDTH-1:0] w_nxt_pc;
  logic [2:0]          w_nxt_nzp;
  logic [DW-1:0]       w_nxt_depth;
  logic                w_nxt_ovf;
  logic                w_nxt_unf;
  logic                w_push;

  logic [4:0]          w_unused_alu;

  assign w_unused_alu = bus.alu_out[7:3];

  assign w_seq      = bus.current_pc + PC_WIDTH'(1);
  assign w_exec     = bus.enable
                   && (bus.core_state == ST_EXEC);
  assign w_upd      = bus.enable
                   && (bus.core_state == ST_UPD);
  assign w_full     = (r_depth == DW'(STACK_DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_taken    = |(r_nzp & bus.decoded_nzp);
  assign w_depth_m1 = r_depth - DW'(1);
  assign w_top_idx  = w_depth_m1[AW-1:0];
  assign w_push_idx = r_depth[AW-1:0];
  assign w_top      = r_stack[w_top_idx];

  // Resolve next PC (RET > CALL > branch > seq) and flag latch.
  always_comb begin
    w_nxt_pc    = r_next_pc;
    w_nxt_nzp   = r_nzp;
    w_nxt_depth = r_depth;
    w_nxt_ovf   = r_ovf;
    w_nxt_unf   = r_unf;
    w_push      = 1'b0;
    if (w_exec) begin
      if (bus.decoded_ret) begin
        if (!w_empty) begin
          w_nxt_pc    = w_top;
          w_nxt_depth = w_depth_m1;
        end else begin
          w_nxt_pc  = w_seq;
          w_nxt_unf = 1'b1;
        end
      end else if (bus.decoded_call) begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_nxt_depth = r_depth + DW'(1);
          w_nxt_pc    = bus.decoded_immediate;
        end else begin
          w_nxt_pc  = w_seq;
          w_nxt_ovf = 1'b1;
        end
      end else if (bus.decoded_pc_mux && w_taken) begin
        w_nxt_pc = bus.decoded_immediate;
      end else begin
        w_nxt_pc = w_seq;
      end
    end
    if (w_upd && bus.decoded_nzp_write_enable) begin
      w_nxt_nzp = bus.alu_out[2:0];
    end
  end

  // Architectural state; synchronous reset wins over any phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_pc <= '0;
      r_nzp     <= 3'b000;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_next_pc <= w_nxt_pc;
      r_nzp     <= w_nxt_nzp;
      r_depth   <= w_nxt_depth;
      r_ovf     <= w_nxt_ovf;
      r_unf     <= w_nxt_unf;
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_stack[w_push_idx] <= w_seq;
    end
  end

  assign bus.next_pc         = r_next_pc;
  assign bus.nzp             = r_nzp;
  assign bus.stack_depth     = r_depth;
  assign bus.stack_overflow  = r_ovf;
  assign bus.stack_underflow = r_unf;
endmodule

// File: tb/tb_pc_nzp_unit.sv
// tb_pc_nzp_unit: directed plan plus random phases,
// checked against a queue-based reference model.
module tb_pc_nzp_unit;
  logic clk = 1'b0;
  logic reset;

  pc_nzp_unit_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) bus ();

  pc_nzp_unit #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_nzp;
  int m_ovf;
  int m_unf;
  int stk[$];

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".next_pc"}, int'(bus.next_pc), m_pc);
    chk({tag, ".nzp"}, int'(bus.nzp), m_nzp);
    chk({tag, ".depth"}, int'(bus.stack_depth),
        stk.size());
    chk({tag, ".ovf"}, int'(bus.stack_overflow), m_ovf);
    chk({tag, ".unf"}, int'(bus.stack_underflow), m_unf);
  endtask

  task automatic drive(input int en, input int st,
                       input int cpc, input int dnzp,
                       input int imm, input int mux,
                       input int call, input int ret,
                       input int we, input int alu);
    bus.enable                   = en[0];
    bus.core_state               = st[2:0];
    bus.current_pc               = cpc[7:0];
    bus.decoded_nzp              = dnzp[2:0];
    bus.decoded_immediate        = imm[7:0];
    bus.decoded_pc_mux           = mux[0];
    bus.decoded_call             = call[0];
    bus.decoded_ret              = ret[0];
    bus.decoded_nzp_write_enable = we[0];
    bus.alu_out                  = alu[7:0];
  endtask

  task automatic step(input string tag, input int en,
                      input int st, input int cpc,
                      input int dnzp, input int imm,
                      input int mux, input int call,
                      input int ret, input int we,
                      input int alu);
    int seq;
    drive(en, st, cpc, dnzp, imm, mux, call, ret, we, alu);
    @(posedge clk);
    #1;
    seq = (cpc + 1) % 256;
    if (en != 0 && st == 5) begin
      if (ret != 0) begin
        if (stk.size() > 0) m_pc = stk.pop_back();
        else begin
          m_pc  = seq;
          m_unf = 1;
        end
      end else if (call != 0) begin
        if (stk.size() < 4) begin
          stk.push_back(seq);
          m_pc = imm;
        end else begin
          m_pc  = seq;
          m_ovf = 1;
        end
      end else if (mux != 0 && (m_nzp & dnzp) != 0) begin
        m_pc = imm;
      end else begin
        m_pc = seq;
      end
    end
    if (en != 0 && st == 6 && we != 0) m_nzp = alu % 8;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input int st);
    reset = 1'b1;
    drive(1, st, $urandom_range(255), 7, 8'h5A, 1, 1, 0,
          1, 8'hFF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 0; m_nzp = 0; m_ovf = 0; m_unf = 0;
    stk.delete();
    check_all(tag);
  endtask

  task automatic ex(input string tag, input int cpc,
                    input int dnzp, input int imm,
                    input int mux, input int call,
                    input int ret);
    step(tag, 1, 5, cpc, dnzp, imm, mux, call, ret, 0, 0);
  endtask

  task automatic upd(input string tag, input int alu);
    step(tag, 1, 6, 0, 0, 0, 0, 0, 0, 1, alu);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst", 5);

    upd("nzp_z", 8'h02);
    upd("nzp_hi", 8'hFC);
    upd("nzp_z2", 8'h02);

    ex("br_tk", 8'h10, 3'b010, 8'h40, 1, 0, 0);
    ex("br_nt", 8'h10, 3'b101, 8'h40, 1, 0, 0);
    ex("br_000", 8'h10, 3'b000, 8'h40, 1, 0, 0);

    ex("wrap", 8'hFF, 0, 8'h40, 0, 0, 0);
    step("hold", 0, 5, 8'h05, 7, 8'h40, 1, 1, 0, 0, 0);

    ex("call1", 8'h01, 0, 8'h20, 0, 1, 0);
    ex("call2", 8'h21, 0, 8'h30, 0, 1, 0);
    ex("call3", 8'h31, 0, 8'h50, 0, 1, 0);
    ex("ret1", 8'h51, 0, 8'h00, 0, 0, 1);
    ex("ret2", 8'h33, 0, 8'h00, 0, 0, 1);
    ex("ret3", 8'h23, 0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 4; i++)
      ex("fill", 8'h60 + i, 0, 8'h80 + i, 0, 1, 0);
    ex("ovf", 8'h70, 0, 8'hA0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      ex("drain", 8'h88, 0, 0, 0, 0, 1);
    ex("unf", 8'h90, 0, 0, 0, 0, 1);
    ex("sticky", 8'h91, 0, 0, 0, 0, 0);

    do_reset("rst2", 6);
    ex("br111_rst", 8'h20, 3'b111, 8'h99, 1, 0, 0);
    ex("pcall", 8'h32, 0, 8'h60, 0, 1, 0);
    ex("callret", 8'h60, 0, 8'h77, 0, 1, 1);
    step("gate_u", 1, 6, 8'h44, 7, 8'h55, 1, 1, 0, 0,
         8'h07);
    step("gate_e", 1, 5, 8'h44, 0, 8'h55, 0, 0, 0, 1,
         8'h04);
    step("gate_f", 1, 1, 8'h10, 7, 8'h55, 1, 1, 1, 1,
         8'h01);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(99);
      if (r < 3) begin
        do_reset("rnd_rst", $urandom_range(7));
      end else begin
        step("rnd",
             ($urandom_range(7) != 0) ? 1 : 0,
             (r < 45) ? 5 : ((r < 75) ? 6
                              : $urandom_range(7)),
             $urandom_range(255), $urandom_range(7),
             $urandom_range(255),
             $urandom_range(1),
             ($urandom_range(3) == 0) ? 1 : 0,
             ($urandom_range(3) == 0) ? 1 : 0,
             $urandom_range(1), $urandom_range(255));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
